// File: rtl/frvp_spi_pipe_pkg.sv
// ----------------------------------------------------------------------------
// frvp_spi_pipe_pkg : limits and sizing helper for the SPI elastic pipeline
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package frvp_spi_pipe_pkg;

  localparam int MAX_WIDTH = 64;
  localparam int MAX_DEPTH = 16;

  // Occupancy ranges over 0..depth inclusive, hence depth+1 encodings.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/frvp_spi_async_reset_stage.sv
// ----------------------------------------------------------------------------
// frvp_spi_async_reset_stage : one valid bit plus one data word, async reset
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module frvp_spi_async_reset_stage
  import frvp_spi_pipe_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rstnn,
  input  logic             load,
  input  logic             flush,
  input  logic             v_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             v_out,
  output logic [WIDTH-1:0] d_out
);

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      v_out <= 1'b0;
      d_out <= RESET_VALUE;
    end else begin
      if (flush) begin
        v_out <= 1'b0;
      end else if (load) begin
        v_out <= v_in;
      end
      // Bubbles leave the data register alone to avoid needless toggling.
      if (load && v_in && !flush) begin
        d_out <= d_in;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/frvp_spi_async_reset_pipe.sv
// ----------------------------------------------------------------------------
// frvp_spi_async_reset_pipe : elastic ready/valid pipeline of DEPTH stages
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module frvp_spi_async_reset_pipe
  import frvp_spi_pipe_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_W       = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rstnn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH:0]   adv;
  logic             push;
  logic             pop;

  // A stage may load when it is empty or its successor is loading too.
  always_comb begin
    adv        = '0;
    adv[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv[i] = !v[i] || adv[i+1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      frvp_spi_async_reset_stage #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
      ) u_stage (
        .clk   (clk),
        .rstnn (rstnn),
        .load  (adv[i]),
        .flush (flush),
        .v_in  (in_valid),
        .d_in  (in_data),
        .v_out (v[i]),
        .d_out (d[i])
      );
    end else begin : g_rest
      frvp_spi_async_reset_stage #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
      ) u_stage (
        .clk   (clk),
        .rstnn (rstnn),
        .load  (adv[i]),
        .flush (flush),
        .v_in  (v[i-1]),
        .d_in  (d[i-1]),
        .v_out (v[i]),
        .d_out (d[i])
      );
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + CNT_W'(1);
    end else if (pop && !push) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

`default_nettype wire
